// File: rtl/fb_stream_writer_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg : shared definitions for the framebuffer stream writer.
//   Framebuffer geometry (320x240, 8 bpp), address/data widths, the last
//   linear address and the writer state encoding.
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int H_RES     = 320;
    localparam int V_RES     = 240;
    localparam int FB_PIXELS = H_RES * V_RES;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;

    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } fb_wr_state_t;

endpackage

// File: rtl/fb_stream_writer_addr_counter.sv
// ---------------------------------------------------------------------------
// fb_addr_counter : wrapping linear framebuffer pointer 0..FB_LAST.
//   Used as the pixel write pointer and as the clear-sweep address.
// Ports:
//   clock_i  - clock
//   reset_i  - asynchronous active-high reset (pointer -> 0)
//   load0_i  - force pointer to 0 (highest priority)
//   load1_i  - force pointer to 1
//   inc_i    - advance pointer, wrapping FB_LAST -> 0
//   count_o  - current pointer value
//   last_o   - pointer currently equals FB_LAST
// ---------------------------------------------------------------------------
module fb_addr_counter
    import fb_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load0_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    assign last_o  = (count_q == FB_LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (load0_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = ADDR_W'(1);
        end else if (inc_i) begin
            count_d = last_o ? '0 : count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fb_stream_writer.sv
// ---------------------------------------------------------------------------
// fb_stream_writer : write-side client of the 320x240x8 framebuffer RAM.
//   Takes a valid/ready pixel stream, assigns sequential addresses (frame
//   aligned by s_sof) and writes through a one-entry hold register only in
//   cycles where the display reader does not own the RAM port.
//
// Optional feature macro: FB_WRITER_CLEAR_EN
//   defined   - after reset and on clear_req the whole buffer is swept with
//               FILL_COLOR; clearing is high during the sweep.
//   undefined - no clear state, clear_req ignored, clearing tied low.
//
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   s_valid/s_ready       - pixel stream handshake
//   s_data, s_sof         - pixel value, start-of-frame marker
//   port_busy             - reader owns the RAM port this cycle
//   clear_req             - one-cycle request to restart the clear sweep
//   ram_address/data_in   - write address / data (from the hold register)
//   ram_wren              - write strobe
//   frame_done            - pulse after the write of the last address
//   sof_err               - pulse after an s_sof beat with pointer != 0
//   clearing              - clear sweep in progress
// ---------------------------------------------------------------------------
module fb_stream_writer
    import fb_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              port_busy,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wren,
    output logic              frame_done,
    output logic              sof_err,
    output logic              clearing
);

`ifdef FB_WRITER_CLEAR_EN
    localparam fb_wr_state_t RESET_ST = ST_CLEAR;
`else
    localparam fb_wr_state_t RESET_ST = ST_WAIT_SOF;
`endif

    fb_wr_state_t      state_q, state_d;
    logic              hold_full_q, hold_full_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              frame_done_q, frame_done_d;
    logic              sof_err_q, sof_err_d;

    logic              clr_go;
    logic              accept;
    logic              load_pix;
    logic              ptr_load0, ptr_load1, ptr_inc;
    logic [ADDR_W-1:0] ptr;
    logic              ptr_last;

`ifdef FB_WRITER_CLEAR_EN
    assign clr_go   = clear_req;
    assign clearing = (state_q == ST_CLEAR);
`else
    assign clr_go   = 1'b0;
    assign clearing = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{clear_req, FILL_COLOR, ptr_last};
`endif

    fb_addr_counter u_ptr (
        .clock_i (clock),
        .reset_i (reset),
        .load0_i (ptr_load0),
        .load1_i (ptr_load1),
        .inc_i   (ptr_inc),
        .count_o (ptr),
        .last_o  (ptr_last)
    );

    // A pending clear request discards the held beat, so it also blocks the
    // write and the handshake in that cycle.
    assign ram_wren    = hold_full_q & ~port_busy & ~clr_go;
    assign s_ready     = (state_q != ST_CLEAR) & (~hold_full_q | ~port_busy) & ~clr_go;
    assign accept      = s_valid & s_ready;
    // In WAIT_SOF only the s_sof beat is stored; others are dropped.
    assign load_pix    = accept & ((state_q == ST_RUN) | s_sof);

    assign ram_address = hold_addr_q;
    assign ram_data_in = hold_data_q;
    assign frame_done  = frame_done_q;
    assign sof_err     = sof_err_q;

    always_comb begin
        state_d      = state_q;
        hold_full_d  = hold_full_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        ptr_load0    = 1'b0;
        ptr_load1    = 1'b0;
        ptr_inc      = 1'b0;
        sof_err_d    = 1'b0;
        frame_done_d = ram_wren & (hold_addr_q == FB_LAST) & (state_q != ST_CLEAR);

        if (ram_wren) begin
            hold_full_d = 1'b0;
        end

        // Pixel path; load_pix is never set in CLEAR or on a clear request.
        if (load_pix) begin
            hold_full_d = 1'b1;
            hold_data_d = s_data;
            if (s_sof) begin
                hold_addr_d = '0;
                ptr_load1   = 1'b1;
                state_d     = ST_RUN;
                sof_err_d   = (state_q == ST_RUN) & (ptr != '0);
            end else begin
                hold_addr_d = ptr;
                ptr_inc     = 1'b1;
            end
        end

`ifdef FB_WRITER_CLEAR_EN
        if (clr_go) begin
            // Restart: address 0 is preloaded so its write can go next cycle.
            state_d     = ST_CLEAR;
            hold_full_d = 1'b1;
            hold_addr_d = '0;
            hold_data_d = FILL_COLOR;
            ptr_load1   = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            if (!hold_full_q || ram_wren) begin
                if (hold_full_q && (hold_addr_q == FB_LAST)) begin
                    // Final fill written: hold empties, back to frame sync.
                    state_d   = ST_WAIT_SOF;
                    ptr_load0 = 1'b1;
                end else begin
                    hold_full_d = 1'b1;
                    hold_addr_d = ptr;
                    hold_data_d = FILL_COLOR;
                    ptr_inc     = 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_ST;
            hold_full_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

endmodule
